// File: rtl/oe_word_checker.sv
// oe_word_checker: resolves undriven bits of o/oe words to a pull value and checks them against exp
// over a run of NSAMP samples, reporting pass, a saturating error count and the first mismatch signature.
module oe_word_checker #(
   parameter int WIDTH = 32,
   parameter int NSAMP = 4,
   parameter bit PULL  = 1'b0
) (
   input  logic             clk,
   input  logic             reset_l,
   input  logic             start,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] o,
   input  logic [WIDTH-1:0] oe,
   input  logic [WIDTH-1:0] exp,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [7:0]       err_count,
   output logic [WIDTH-1:0] first_bad
);
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   state_t           state;
   logic [7:0]       cnt;
   logic [WIDTH-1:0] resolved;
   logic [WIDTH-1:0] diff;
   logic             mismatch;
   logic             accept;
   assign resolved = (o & oe) | (~oe & {WIDTH{PULL}});
   assign diff     = resolved ^ exp;
   assign mismatch = |diff;
   assign accept   = in_valid && in_ready;
   always_ff @(posedge clk) begin
      if (!reset_l) begin
         state     <= IDLE;
         in_ready  <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         pass      <= 1'b0;
         err_count <= 8'd0;
         first_bad <= '0;
         cnt       <= 8'd0;
      end else begin
         case (state)
            IDLE, DONE: if (start) begin
               state     <= RUN;
               in_ready  <= 1'b1;
               busy      <= 1'b1;
               done      <= 1'b0;
               pass      <= 1'b0;
               err_count <= 8'd0;
               first_bad <= '0;
               cnt       <= 8'd0;
            end
            RUN: if (accept) begin
               cnt <= cnt + 8'd1;
               if (mismatch && err_count != 8'd255) err_count <= err_count + 8'd1;
               if (mismatch && err_count == 8'd0) first_bad <= diff;
               // pass reflects the count including this final sample
               if (cnt == 8'(NSAMP - 1)) begin
                  state    <= DONE;
                  in_ready <= 1'b0;
                  busy     <= 1'b0;
                  done     <= 1'b1;
                  pass     <= (err_count == 8'd0) && !mismatch;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_oe_word_checker.sv
// tb_oe_word_checker: directed checks of oe_word_checker across four parameterisations
// sharing one stimulus bus.
module tb_oe_word_checker;
   logic        clk = 1'b0;
   logic        reset_l = 1'b0;
   logic        start = 1'b0;
   logic        in_valid = 1'b0;
   logic [31:0] o = '0;
   logic [31:0] oe = '0;
   logic [31:0] exp = '0;
   int          checks = 0;
   int          errors = 0;

   logic        a_rdy, a_busy, a_done, a_pass;
   logic [7:0]  a_err;
   logic [31:0] a_fb;
   logic        b_rdy, b_busy, b_done, b_pass;
   logic [7:0]  b_err;
   logic [31:0] b_fb;
   logic        c_rdy, c_busy, c_done, c_pass;
   logic [7:0]  c_err;
   logic [31:0] c_fb;
   logic        d_rdy, d_busy, d_done, d_pass;
   logic [7:0]  d_err;
   logic [31:0] d_fb;

   always #5 clk = ~clk;

   oe_word_checker #(.WIDTH(32), .NSAMP(1), .PULL(1'b0)) u_a (
      .clk(clk), .reset_l(reset_l), .start(start), .in_valid(in_valid), .in_ready(a_rdy),
      .o(o), .oe(oe), .exp(exp), .busy(a_busy), .done(a_done), .pass(a_pass),
      .err_count(a_err), .first_bad(a_fb));
   oe_word_checker #(.WIDTH(32), .NSAMP(4), .PULL(1'b1)) u_b (
      .clk(clk), .reset_l(reset_l), .start(start), .in_valid(in_valid), .in_ready(b_rdy),
      .o(o), .oe(oe), .exp(exp), .busy(b_busy), .done(b_done), .pass(b_pass),
      .err_count(b_err), .first_bad(b_fb));
   oe_word_checker #(.WIDTH(32), .NSAMP(4), .PULL(1'b0)) u_c (
      .clk(clk), .reset_l(reset_l), .start(start), .in_valid(in_valid), .in_ready(c_rdy),
      .o(o), .oe(oe), .exp(exp), .busy(c_busy), .done(c_done), .pass(c_pass),
      .err_count(c_err), .first_bad(c_fb));
   oe_word_checker #(.WIDTH(32), .NSAMP(255), .PULL(1'b0)) u_d (
      .clk(clk), .reset_l(reset_l), .start(start), .in_valid(in_valid), .in_ready(d_rdy),
      .o(o), .oe(oe), .exp(exp), .busy(d_busy), .done(d_done), .pass(d_pass),
      .err_count(d_err), .first_bad(d_fb));

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset_l = 1'b0;
      start = 1'b0;
      in_valid = 1'b0;
      step();
      reset_l = 1'b1;
   endtask

   task automatic kick();
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if ({c_rdy, c_busy, c_done, c_pass} !== 4'b0000) begin
         errors++;
         $display("FAIL reset_flags got %b want 0000", {c_rdy, c_busy, c_done, c_pass});
      end
      checks++;
      if (c_err !== 8'd0 || c_fb !== 32'd0) begin
         errors++;
         $display("FAIL reset_counts got err=%0d fb=%h want 0/0", c_err, c_fb);
      end
   endtask

   task automatic test_single();
      do_reset();
      kick();
      checks++;
      if ({a_busy, a_rdy, a_done} !== 3'b110) begin
         errors++;
         $display("FAIL single_run got %b want 110", {a_busy, a_rdy, a_done});
      end
      o = 32'h1; oe = 32'h1; exp = 32'h1; in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      checks++;
      if ({a_done, a_pass, a_busy, a_rdy} !== 4'b1100) begin
         errors++;
         $display("FAIL single_done got %b want 1100", {a_done, a_pass, a_busy, a_rdy});
      end
      checks++;
      if (a_err !== 8'd0 || a_fb !== 32'd0) begin
         errors++;
         $display("FAIL single_counts got err=%0d fb=%h want 0/0", a_err, a_fb);
      end
   endtask

   task automatic test_pull();
      do_reset();
      kick();
      o = 32'h0; oe = 32'h0000FFFF; exp = 32'hFFFF0000; in_valid = 1'b1;
      repeat (4) step();
      in_valid = 1'b0;
      checks++;
      if ({b_done, b_pass} !== 2'b11 || b_err !== 8'd0) begin
         errors++;
         $display("FAIL pullup got done/pass=%b err=%0d want 11/0", {b_done, b_pass}, b_err);
      end
      checks++;
      if ({c_done, c_pass} !== 2'b10 || c_err !== 8'd4 || c_fb !== 32'hFFFF0000) begin
         errors++;
         $display("FAIL pulldown got done/pass=%b err=%0d fb=%h want 10/4/ffff0000",
                  {c_done, c_pass}, c_err, c_fb);
      end
   endtask

   task automatic test_first_bad();
      do_reset();
      kick();
      in_valid = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         if (i % 2 == 0) begin
            o = 32'h12345679; oe = 32'hFFFFFFFE; exp = 32'h12345679;
         end else begin
            o = 32'hA5A5A5A5; oe = 32'hFFFFFFFF; exp = 32'hA5A5A5A5;
         end
         step();
         if (i == 2) begin
            checks++;
            if (c_err !== 8'd1 || c_fb !== 32'h1 || c_done !== 1'b0) begin
               errors++;
               $display("FAIL first_bad_mid got err=%0d fb=%h done=%b want 1/1/0", c_err, c_fb, c_done);
            end
         end
      end
      in_valid = 1'b0;
      checks++;
      if (c_err !== 8'd2 || c_fb !== 32'h1 || {c_done, c_pass} !== 2'b10) begin
         errors++;
         $display("FAIL first_bad_end got err=%0d fb=%h done/pass=%b want 2/1/10",
                  c_err, c_fb, {c_done, c_pass});
      end
   endtask

   task automatic test_backpressure();
      int n;
      logic rdy;
      do_reset();
      o = 32'h0; oe = 32'hFFFFFFFF; exp = 32'hFFFFFFFF; in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         step();
         checks++;
         if (c_rdy !== 1'b0 || c_err !== 8'd0 || c_busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_ignore cycle %0d got rdy=%b err=%0d busy=%b want 0/0/0", i, c_rdy, c_err, c_busy);
         end
      end
      in_valid = 1'b0;
      exp = 32'h0;
      kick();
      n = 0;
      for (int i = 0; i < 8; i++) begin
         in_valid = (i % 2 == 0);
         rdy = c_rdy;
         if (i == 6) begin
            checks++;
            if (c_done !== 1'b0) begin
               errors++;
               $display("FAIL early_done got %b want 0", c_done);
            end
         end
         step();
         if (in_valid && rdy) n++;
      end
      in_valid = 1'b0;
      checks++;
      if (n != 4 || {c_done, c_pass} !== 2'b11) begin
         errors++;
         $display("FAIL toggle_accepts got n=%0d done/pass=%b want 4/11", n, {c_done, c_pass});
      end
   endtask

   task automatic test_reset_mid_run();
      do_reset();
      kick();
      in_valid = 1'b1;
      o = 32'h0; oe = 32'hFFFFFFFF; exp = 32'h80;
      step();
      exp = 32'h0;
      step();
      checks++;
      if (c_err !== 8'd1 || c_fb !== 32'h80) begin
         errors++;
         $display("FAIL mid_run got err=%0d fb=%h want 1/80", c_err, c_fb);
      end
      reset_l = 1'b0;
      step();
      reset_l = 1'b1;
      in_valid = 1'b0;
      checks++;
      if ({c_busy, c_rdy, c_done} !== 3'b000 || c_err !== 8'd0 || c_fb !== 32'h0) begin
         errors++;
         $display("FAIL mid_reset got flags=%b err=%0d fb=%h want 000/0/0", {c_busy, c_rdy, c_done}, c_err, c_fb);
      end
      kick();
      in_valid = 1'b1;
      repeat (4) step();
      in_valid = 1'b0;
      checks++;
      if ({c_done, c_pass} !== 2'b11 || c_err !== 8'd0) begin
         errors++;
         $display("FAIL fresh_run got done/pass=%b err=%0d want 11/0", {c_done, c_pass}, c_err);
      end
   endtask

   task automatic test_saturation();
      do_reset();
      kick();
      o = 32'h0; oe = 32'hFFFFFFFF; exp = 32'h1; in_valid = 1'b1;
      repeat (254) step();
      checks++;
      if (d_done !== 1'b0 || d_err !== 8'd254) begin
         errors++;
         $display("FAIL sat_pre got done=%b err=%0d want 0/254", d_done, d_err);
      end
      step();
      checks++;
      if ({d_done, d_pass} !== 2'b10 || d_err !== 8'd255 || d_fb !== 32'h1) begin
         errors++;
         $display("FAIL sat_done got done/pass=%b err=%0d fb=%h want 10/255/1", {d_done, d_pass}, d_err, d_fb);
      end
      step();
      checks++;
      if (d_err !== 8'd255 || d_done !== 1'b1) begin
         errors++;
         $display("FAIL sat_hold got err=%0d done=%b want 255/1", d_err, d_done);
      end
      in_valid = 1'b0;
      kick();
      checks++;
      if ({d_busy, d_rdy, d_done} !== 3'b110 || d_err !== 8'd0 || d_fb !== 32'h0) begin
         errors++;
         $display("FAIL restart got flags=%b err=%0d fb=%h want 110/0/0", {d_busy, d_rdy, d_done}, d_err, d_fb);
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_pull();
      test_first_bad();
      test_backpressure();
      test_reset_mid_run();
      test_saturation();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
